layer_seq: RTL

LAYER_SEQ -- requirements
Module: layer_seq

---
 rtl/layer_seq.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/layer_seq.sv
// layer_seq: time-multiplexed fully connected layer.
// PAR neurons form a group. A group takes one input per cycle into PAR
// accumulators, then spends one cycle on bias, shift, saturation and the
// optional ReLU. Groups are processed in order until all OUT_NUM outputs
// have been written.
module layer_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int W_BITS     = 8,
    parameter int B_BITS     = 16,
    parameter int IN_NUM     = 16,
    parameter int OUT_NUM    = 8,
    parameter int PAR        = 2,
    parameter int SHIFT      = 0,
    parameter int OUT_WIDTH  = DATA_WIDTH + 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 act_mode,
    input  logic [IN_NUM*DATA_WIDTH-1:0]         data_in,
    input  logic [OUT_NUM*IN_NUM*W_BITS-1:0]     weights,
    input  logic [OUT_NUM*B_BITS-1:0]            bias,
    output logic                                 busy,
    output logic                                 done,
    output logic [OUT_NUM*OUT_WIDTH-1:0]         data_out
);

    // An uneven split would leave neurons that no group ever computes.
    generate
        if (OUT_NUM % PAR != 0) begin : g_par_check
            $error("layer_seq: OUT_NUM must be a multiple of PAR");
        end
    endgenerate

    localparam int GROUPS = OUT_NUM / PAR;
    // One extra bit beyond the worst-case product sum keeps accumulation exact.
    localparam int ACC_W  = DATA_WIDTH + W_BITS + $clog2(IN_NUM) + 1;
    localparam int SUM_W0 = (ACC_W > B_BITS) ? ACC_W : B_BITS;
    // Wide enough for acc + bias and for holding the output range limits.
    localparam int SUM_W  = ((SUM_W0 > OUT_WIDTH) ? SUM_W0 : OUT_WIDTH) + 1;
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int JW     = (IN_NUM > 1) ? $clog2(IN_NUM) : 1;

    localparam logic [GW-1:0] LAST_G = GW'(GROUPS - 1);
    localparam logic [JW-1:0] LAST_J = JW'(IN_NUM - 1);

    localparam logic signed [SUM_W-1:0] MAX_V =
        {{(SUM_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] MIN_V =
        {{(SUM_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MAC  = 2'd1;
    localparam logic [1:0] ACT  = 2'd2;
    localparam logic [1:0] FIN  = 2'd3;

    logic [1:0]                  stateQ, stateD;
    logic [GW-1:0]               gQ, gD;
    logic [JW-1:0]               jQ, jD;
    logic                        modeQ, modeD;
    logic                        doneQ, doneD;
    logic signed [DATA_WIDTH-1:0] xQ   [IN_NUM];
    logic signed [DATA_WIDTH-1:0] xD   [IN_NUM];
    logic signed [ACC_W-1:0]      accQ [PAR];
    logic signed [ACC_W-1:0]      accD [PAR];
    logic signed [OUT_WIDTH-1:0]  outQ [OUT_NUM];
    logic signed [OUT_WIDTH-1:0]  outD [OUT_NUM];

    logic signed [W_BITS-1:0]     wSel [PAR];
    logic signed [B_BITS-1:0]     bSel [PAR];
    logic signed [SUM_W-1:0]      sumV;
    logic signed [SUM_W-1:0]      shV;
    logic signed [OUT_WIDTH-1:0]  satV;

    // Pick the weight for input j and the bias of each neuron in the current group.
    always_comb begin
        for (int p = 0; p < PAR; p++) begin
            wSel[p] = weights[((int'(gQ) * PAR + p) * IN_NUM + int'(jQ)) * W_BITS +: W_BITS];
            bSel[p] = bias[(int'(gQ) * PAR + p) * B_BITS +: B_BITS];
        end
    end

    // Next-state logic: capture, accumulate, finish a group, signal completion.
    always_comb begin
        stateD = stateQ;
        gD     = gQ;
        jD     = jQ;
        modeD  = modeQ;
        doneD  = 1'b0;
        xD     = xQ;
        accD   = accQ;
        outD   = outQ;
        sumV   = '0;
        shV    = '0;
        satV   = '0;
        case (stateQ)
            IDLE: begin
                if (start) begin
                    for (int i = 0; i < IN_NUM; i++) begin
                        xD[i] = data_in[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                    for (int p = 0; p < PAR; p++) begin
                        accD[p] = '0;
                    end
                    modeD  = act_mode;
                    gD     = '0;
                    jD     = '0;
                    stateD = MAC;
                end
            end
            MAC: begin
                for (int p = 0; p < PAR; p++) begin
                    accD[p] = accQ[p] + ACC_W'(xQ[jQ]) * ACC_W'(wSel[p]);
                end
                if (jQ == LAST_J) begin
                    jD     = '0;
                    stateD = ACT;
                end else begin
                    jD = jQ + JW'(1);
                end
            end
            ACT: begin
                for (int p = 0; p < PAR; p++) begin
                    sumV = SUM_W'(accQ[p]) + SUM_W'(bSel[p]);
                    shV  = sumV >>> SHIFT;
                    if (shV > MAX_V) begin
                        satV = MAX_V[OUT_WIDTH-1:0];
                    end else if (shV < MIN_V) begin
                        satV = MIN_V[OUT_WIDTH-1:0];
                    end else begin
                        satV = shV[OUT_WIDTH-1:0];
                    end
                    if (modeQ && satV[OUT_WIDTH-1]) begin
                        satV = '0;
                    end
                    outD[int'(gQ) * PAR + p] = satV;
                    accD[p] = '0;
                end
                jD = '0;
                if (gQ == LAST_G) begin
                    stateD = FIN;
                end else begin
                    gD     = gQ + GW'(1);
                    stateD = MAC;
                end
            end
            FIN: begin
                // done is registered, so the pulse appears on the edge leaving FIN.
                doneD  = 1'b1;
                gD     = '0;
                stateD = IDLE;
            end
            default: begin
                stateD = IDLE;
            end
        endcase
    end

    // State registers; reset aborts any run and clears every output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= IDLE;
            gQ     <= '0;
            jQ     <= '0;
            modeQ  <= 1'b0;
            doneQ  <= 1'b0;
            for (int i = 0; i < IN_NUM; i++) begin
                xQ[i] <= '0;
            end
            for (int p = 0; p < PAR; p++) begin
                accQ[p] <= '0;
            end
            for (int o = 0; o < OUT_NUM; o++) begin
                outQ[o] <= '0;
            end
        end else begin
            stateQ <= stateD;
            gQ     <= gD;
            jQ     <= jD;
            modeQ  <= modeD;
            doneQ  <= doneD;
            xQ     <= xD;
            accQ   <= accD;
            outQ   <= outD;
        end
    end

    // Flatten the output registers onto the port.
    always_comb begin
        data_out = '0;
        for (int o = 0; o < OUT_NUM; o++) begin
            data_out[o*OUT_WIDTH +: OUT_WIDTH] = outQ[o];
        end
    end

    assign busy = (stateQ != IDLE);
    assign done = doneQ;

endmodule
